instruction_encoder: RTL and testbench

- Inverse of the core's instruction decoder: takes symbolic instruction descriptors for the supported subset and emits encoded 32-bit MIPS words, each tagged with its instruction-memory byte address.
- Used by the program loader and self-test generator to fill instruction memory.
- Descriptor in via valid/ready, word out via valid/ready, with a 2-entry output FIFO between them.
- Session FSM: start, stream, drain, done.

---
 rtl/instruction_encoder.sv | 178 +++++++++++++++++
 tb/tb_instruction_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// instruction_encoder: turns symbolic instruction descriptors into encoded
// 32-bit MIPS words tagged with their instruction-memory byte address.
// Descriptors enter via valid/ready; words leave through a 2-entry FIFO.
// Optional label-relative branch/jump encoding: define INSTR_ENC_LABEL_EN.
module instruction_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_3000),
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm16,
    input  logic [25:0]       in_target,
    input  logic [31:0]       in_label,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  word_count,
    output logic              done,
    output logic              err_illegal
);

    localparam int ENTRY_W = ADDR_W + 32;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]    wc_q, wc_d;
    logic                err_q, err_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]  fifo_mem_q [2];
    logic [ENTRY_W-1:0]  fifo_head;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic [15:0]         beq_imm;
    logic [25:0]         jmp_target;
    logic                label_misaligned;
    logic                accept, push, pop;
    logic                fifo_full, fifo_empty;

`ifdef INSTR_ENC_LABEL_EN
    logic [ADDR_W-1:0]   label_delta;
    logic                unused_target;

    // Branch offset is word-granular and relative to the delay-slot PC.
    assign label_delta      = ADDR_W'(in_label) - (pc_q + ADDR_W'(4));
    assign beq_imm          = 16'($signed(label_delta) >>> 2);
    assign jmp_target       = in_label[27:2];
    assign label_misaligned = (in_label[1:0] != 2'b00);
    assign unused_target    = ^in_target;
`else
    logic                unused_label;

    assign beq_imm          = in_imm16;
    assign jmp_target       = in_target;
    assign label_misaligned = 1'b0;
    assign unused_label     = ^in_label;
`endif

    assign fifo_full  = (cnt_q == 2'd2);
    assign fifo_empty = (cnt_q == 2'd0);
    // in_ready deliberately ignores out_ready: no combinational path through.
    assign in_ready   = (state_q == S_RUN) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && enc_legal;
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;

    assign fifo_head   = fifo_mem_q[rd_ptr_q];
    assign out_word    = out_valid ? fifo_head[31:0] : 32'd0;
    assign out_addr    = out_valid ? fifo_head[ENTRY_W-1:32] : '0;
    assign word_count  = wc_q;
    assign done        = (state_q == S_DONE);
    assign err_illegal = err_q;

    // Encode the current descriptor and flag illegal opcodes/labels.
    always_comb begin
        enc_word  = 32'd0;
        enc_legal = 1'b1;
        case (in_op)
            4'd0:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
            4'd1:    enc_word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
            4'd2:    enc_word = {6'h00, in_rs, 15'd0, 6'h08};
            4'd3:    enc_word = 32'h0000_000C;
            4'd4:    enc_word = {6'h0D, in_rs, in_rt, in_imm16};
            4'd5:    enc_word = {6'h0F, 5'd0, in_rt, in_imm16};
            4'd6:    enc_word = {6'h23, in_rs, in_rt, in_imm16};
            4'd7:    enc_word = {6'h2B, in_rs, in_rt, in_imm16};
            4'd8:    enc_word = {6'h04, in_rs, in_rt, beq_imm};
            4'd9:    enc_word = {6'h02, jmp_target};
            4'd10:   enc_word = {6'h03, jmp_target};
            default: enc_legal = 1'b0;
        endcase
        if ((in_op == 4'd8 || in_op == 4'd9 || in_op == 4'd10) && label_misaligned) begin
            enc_legal = 1'b0;
        end
    end

    // Session FSM plus PC, word counter and sticky error next-state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wc_d    = wc_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = BASE_ADDR;
                    wc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN:   if (accept && in_last) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // push/pop only happen outside IDLE, so these never collide with start.
        if (push)                  pc_d  = pc_q + ADDR_W'(4);
        if (accept && !enc_legal)  err_d = 1'b1;
        if (pop)                   wc_d  = wc_q + CNT_W'(1);
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control registers; reset discards any queued words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= BASE_ADDR;
            wc_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wc_q     <= wc_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage: contents need no reset because outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {pc_q, enc_word};
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder; scoreboard of {addr, word}.
// Honours INSTR_ENC_LABEL_EN for the label-dependent expectations.
module tb_instruction_encoder;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_ready, in_last;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm16;
    logic [25:0] in_target;
    logic [31:0] in_label;
    logic        out_valid, out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic [15:0] word_count;
    logic        done, err_illegal;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb [$];
    logic [31:0] exp_pc;
    logic        done_at_neg, acc_at_neg;

    instruction_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm16(in_imm16), .in_target(in_target), .in_label(in_label),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .word_count(word_count),
        .done(done), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge (scoreboard pop on handshake), return #1 after posedge.
    task automatic cyc();
        logic [63:0] e;
        @(negedge clk);
        done_at_neg = done;
        acc_at_neg  = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", {32'd0, out_word}, 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("out_word", {32'd0, out_word}, {32'd0, e[31:0]});
                chk("out_addr", {32'd0, out_addr}, {32'd0, e[63:32]});
                $display("word addr=%h data=%h", out_addr, out_word);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start  = 1'b0;
        exp_pc = 32'h0000_3000;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                         input logic [31:0] lbl, input logic last, input logic legal,
                         input logic [31:0] word);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm16 = imm; in_target = tgt; in_label = lbl; in_last = last;
        in_valid = 1'b1;
        if (legal) begin
            sb.push_back({exp_pc, word});
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic wait_accept(input string tag);
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (acc_at_neg) begin
                in_valid = 1'b0;
                return;
            end
        end
        chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (done_at_neg) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
        cyc();
        chk({tag, "_done_pulse"}, {63'd0, done_at_neg}, 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_imm16 = '0; in_target = '0; in_label = '0; out_ready = 1'b1;
        exp_pc = 32'h0000_3000;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err_illegal}, 64'd0);
        chk("rst_word_count", {48'd0, word_count}, 64'd0);
        chk("rst_out_word", {32'd0, out_word}, 64'd0);
        chk("rst_out_addr", {32'd0, out_addr}, 64'd0);

        // Single addu with last.
        do_start();
        chk("run_in_ready", {63'd0, in_ready}, 64'd1);
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 32'h0022_1821);
        wait_accept("addu");
        chk("drain_in_ready", {63'd0, in_ready}, 64'd0);
        wait_done("single");
        chk("single_word_count", {48'd0, word_count}, 64'd1);

        // Stream of I-type / jr / syscall.
        do_start();
        drive(4'd4, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h0, 1'b0, 1'b1, 32'h3401_1234);
        wait_accept("ori");
        drive(4'd5, 5'd0, 5'd2, 5'd0, 16'hABCD, 26'h0, 32'h0, 1'b0, 1'b1, 32'h3C02_ABCD);
        wait_accept("lui");
        drive(4'd6, 5'd5, 5'd4, 5'd0, 16'h0008, 26'h0, 32'h0, 1'b0, 1'b1, 32'h8CA4_0008);
        wait_accept("lw");
        drive(4'd7, 5'd5, 5'd4, 5'd0, 16'h0008, 26'h0, 32'h0, 1'b0, 1'b1, 32'hACA4_0008);
        wait_accept("sw");
        drive(4'd2, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h03E0_0008);
        wait_accept("jr");
        drive(4'd3, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 32'h0000_000C);
        wait_accept("syscall");
        wait_done("stream");
        chk("stream_word_count", {48'd0, word_count}, 64'd6);
        chk("stream_err", {63'd0, err_illegal}, 64'd0);

        // Backpressure: FIFO fills after two accepts, head held stable.
        out_ready = 1'b0;
        do_start();
        drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h0022_1823);
        wait_accept("bp_subu");
        drive(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h0085_3021);
        wait_accept("bp_addu");
        drive(4'd4, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0, 32'h0, 1'b1, 1'b1, 32'h3401_1234);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_hold_word", {32'd0, out_word}, 64'h0022_1823);
            chk("bp_hold_addr", {32'd0, out_addr}, 64'h3000);
        end
        out_ready = 1'b1;
        wait_accept("bp_ori");
        wait_done("bp");
        chk("bp_word_count", {48'd0, word_count}, 64'd3);

        // Illegal opcode between two addu.
        do_start();
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h0022_1821);
        wait_accept("ill_addu0");
        drive(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        wait_accept("ill_op12");
        chk("ill_err_set", {63'd0, err_illegal}, 64'd1);
        drive(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 32'h0085_3021);
        wait_accept("ill_addu1");
        wait_done("ill");
        chk("ill_word_count", {48'd0, word_count}, 64'd2);
        chk("ill_err_sticky", {63'd0, err_illegal}, 64'd1);
        do_start();
        chk("start_clears_err", {63'd0, err_illegal}, 64'd0);

        // beq / j / jal: raw fields and labels chosen to agree, jal label misaligned.
        drive(4'd8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h0000_3000, 1'b0, 1'b1, 32'h1022_FFFF);
        wait_accept("beq");
        drive(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0C04, 32'h0000_3010, 1'b0, 1'b1, 32'h0800_0C04);
        wait_accept("j");
`ifdef INSTR_ENC_LABEL_EN
        drive(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0123, 32'h0000_3002, 1'b1, 1'b0, 32'h0);
        wait_accept("jal");
        wait_done("label");
        chk("label_err", {63'd0, err_illegal}, 64'd1);
        chk("label_word_count", {48'd0, word_count}, 64'd2);
`else
        drive(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0123, 32'h0000_3002, 1'b1, 1'b1, 32'h0C00_0123);
        wait_accept("jal");
        wait_done("label");
        chk("label_err", {63'd0, err_illegal}, 64'd0);
        chk("label_word_count", {48'd0, word_count}, 64'd3);
`endif

        // Reset mid-stream with two words queued.
        do_start();
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h0022_1821);
        wait_accept("mid_addu0");
        cyc();
        out_ready = 1'b0;
        chk("mid_word_count", {48'd0, word_count}, 64'd1);
        drive(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h0022_1823);
        wait_accept("mid_subu");
        drive(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 32'h0085_3021);
        wait_accept("mid_addu1");
        chk("mid_queued_valid", {63'd0, out_valid}, 64'd1);
        chk("mid_in_ready_full", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        sb.delete();
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_word_count", {48'd0, word_count}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("mid_rst_out_word", {32'd0, out_word}, 64'd0);
        out_ready = 1'b1;
        cyc();
        chk("mid_rst_idle_valid", {63'd0, out_valid}, 64'd0);

        // Recovery session starts again at the base address.
        do_start();
        drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1, 32'h0022_1821);
        wait_accept("rec_addu");
        wait_done("recover");
        chk("rec_word_count", {48'd0, word_count}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
